// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add done one nibble per clock through a
// 4-bit ripple-carry stage, with valid/ready handshakes on input and output.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, cin)
//   out_valid/out_ready result handshake (sum, cout[, ovf])
//   busy                high while an operation is in flight (RUN or DONE)
// Optional: define NIBBLE_SERIAL_ADDER_OVF_EN to add the signed overflow
// output ovf.

module adder4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0, cin};

endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;

    logic [3:0]       nib_s;
    logic             nib_co;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic             msb_a;
    logic             msb_b;
`endif

    adder4bit u_add (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (carry),
        .s    (nib_s),
        .cout (nib_co)
    );

    // Each nibble result enters at the top, so after NIB shifts the
    // first (LSB) nibble has walked down to bits [3:0].
    always_comb begin
        sum_nxt = sum_sh >> 4;
        sum_nxt[WIDTH-1 -: 4] = nib_s;
    end

    assign last = (cnt == CW'(NIB - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 4;
                    b_sh   <= b_sh >> 4;
                    sum_sh <= sum_nxt;
                    carry  <= nib_co;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        sum  <= sum_nxt;
                        cout <= nib_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    // Operand sign bits are shifted out during RUN, so keep them aside.
    always_ff @(posedge clk) begin
        if (rst) begin
            msb_a <= 1'b0;
            msb_b <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                msb_a <= a[WIDTH-1];
                msb_b <= b[WIDTH-1];
            end
            if (state == RUN && last) begin
                ovf <= (msb_a == msb_b) && (sum_nxt[WIDTH-1] != msb_a);
            end
        end
    end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: randomized and directed checks of
// nibble_serial_adder at WIDTH=16 and WIDTH=4 against an arithmetic model.

module tb_nibble_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    logic        in_valid4;
    logic        in_ready4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic        out_valid4;
    logic        out_ready4;
    logic [3:0]  sum4;
    logic        cout4;
    logic        busy4;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic        ovf;
    logic        ovf4;
`endif

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.WIDTH(16)) u16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    nibble_serial_adder #(.WIDTH(4)) u4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .busy      (busy4)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf4)
`endif
    );

    // Reference: full (WIDTH+1)-bit sum.
    function automatic logic [16:0] ref16(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic c);
        return {1'b0, x} + {1'b0, y} + {16'b0, c};
    endfunction

    function automatic logic ref_ovf16(input logic [15:0] x,
                                       input logic [15:0] y,
                                       input logic c);
        logic [16:0] r;
        r = ref16(x, y, c);
        return (x[15] == y[15]) && (r[15] != x[15]);
    endfunction

    // Drives one transaction on the 16-bit DUT (which must be idle) and
    // returns the result; olat is edges from accept to out_valid, -1 on
    // timeout. rdy_bad flags in_ready seen high while busy.
    task automatic run16(input logic [15:0] ia, input logic [15:0] ib,
                         input logic ic, output logic [15:0] osum,
                         output logic oco, output logic oovf,
                         output int olat, output bit rdy_bad);
        rdy_bad  = 1'b0;
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        cin      = ic;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom);
        olat     = 0;
        while (!out_valid && olat < 20) begin
            if (in_ready) rdy_bad = 1'b1;
            @(posedge clk);
            #1;
            olat++;
        end
        if (!out_valid) olat = -1;
        if (in_ready) rdy_bad = 1'b1;
        osum = sum;
        oco  = cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        oovf = ovf;
`else
        oovf = 1'b0;
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run4(input logic [3:0] ia, input logic [3:0] ib,
                        input logic ic, output logic [3:0] osum,
                        output logic oco, output int olat);
        in_valid4 = 1'b1;
        a4        = ia;
        b4        = ib;
        cin4      = ic;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        olat      = 0;
        while (!out_valid4 && olat < 20) begin
            @(posedge clk);
            #1;
            olat++;
        end
        if (!out_valid4) olat = -1;
        osum       = sum4;
        oco        = cout4;
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        a4         = '0;
        b4         = '0;
        cin4       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, busy, cout, sum} !== {3'b100, 17'h0}) begin
            errors++;
            $display("FAIL reset16 got rdy=%b ov=%b busy=%b co=%b sum=%h want 1 0 0 0 0000",
                     in_ready, out_valid, busy, cout, sum);
        end
        checks++;
        if ({in_ready4, out_valid4, busy4, cout4, sum4} !== {3'b100, 5'h0}) begin
            errors++;
            $display("FAIL reset4 got rdy=%b ov=%b busy=%b co=%b sum=%h want 1 0 0 0 0",
                     in_ready4, out_valid4, busy4, cout4, sum4);
        end
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b want 0", ovf);
        end
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [15:0] va [4] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h0000};
        logic [15:0] vb [4] = '{16'h4321, 16'h0001, 16'hFFFF, 16'h0000};
        logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [16:0] want [4] = '{17'h05555, 17'h10000, 17'h1FFFF, 17'h00001};
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          lat;
        bit          rb;
        for (int i = 0; i < 4; i++) begin
            run16(va[i], vb[i], vc[i], s, co, ov, lat, rb);
            checks++;
            if ({co, s} !== want[i]) begin
                errors++;
                $display("FAIL directed%0d result got %h want %h", i, {co, s}, want[i]);
            end
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL directed%0d latency got %0d want 4", i, lat);
            end
            checks++;
            if (rb !== 1'b0) begin
                errors++;
                $display("FAIL directed%0d in_ready_busy got 1 want 0", i);
            end
            checks++;
            if ({in_ready, out_valid, busy} !== 3'b100) begin
                errors++;
                $display("FAIL directed%0d after_handshake got rdy=%b ov=%b busy=%b want 1 0 0",
                         i, in_ready, out_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] x;
        logic [15:0] y;
        logic        c;
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          lat;
        bit          rb;
        for (int i = 0; i < 40; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            c = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run16(x, y, c, s, co, ov, lat, rb);
            checks++;
            if ({co, s} !== ref16(x, y, c) || lat !== 4 || rb) begin
                errors++;
                $display("FAIL random%0d %h+%h+%b got %h lat %0d want %h lat 4",
                         i, x, y, c, {co, s}, lat, ref16(x, y, c));
            end
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            checks++;
            if (ov !== ref_ovf16(x, y, c)) begin
                errors++;
                $display("FAIL random_ovf%0d got %b want %b", i, ov, ref_ovf16(x, y, c));
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [16:0] want;
        int          n;
        want     = ref16(16'hABCD, 16'h1111, 1'b1);
        in_valid = 1'b1;
        a        = 16'hABCD;
        b        = 16'h1111;
        cin      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n        = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL bp_latency got %0d want 4", n);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom);
            a        = 16'($urandom);
            b        = 16'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, cout, sum} !== {2'b10, want}) begin
                errors++;
                $display("FAIL bp_hold%0d got ov=%b rdy=%b %h want ov=1 rdy=0 %h",
                         i, out_valid, in_ready, {cout, sum}, want);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy, cout, sum} !== {3'b100, want}) begin
            errors++;
            $display("FAIL bp_release got rdy=%b ov=%b busy=%b %h want 1 0 0 %h",
                     in_ready, out_valid, busy, {cout, sum}, want);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({busy, cout, sum} !== {1'b0, want}) begin
            errors++;
            $display("FAIL bp_idle_hold got busy=%b %h want 0 %h", busy, {cout, sum}, want);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          lat;
        bit          rb;
        bit          seen;
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'h0001;
        cin      = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy, cout, sum} !== {3'b100, 17'h0}) begin
            errors++;
            $display("FAIL midrst got rdy=%b ov=%b busy=%b %h want 1 0 0 00000",
                     in_ready, out_valid, busy, {cout, sum});
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_result got 1 want 0");
        end
        run16(16'h0F0F, 16'h00F1, 1'b0, s, co, ov, lat, rb);
        checks++;
        if ({co, s} !== 17'h01000 || lat !== 4) begin
            errors++;
            $display("FAIL midrst_next got %h lat %0d want 01000 lat 4", {co, s}, lat);
        end
    endtask

    task automatic test_width4();
        logic [3:0] x;
        logic [3:0] y;
        logic       c;
        logic [3:0] s;
        logic       co;
        logic [4:0] want;
        int         lat;
        run4(4'h9, 4'h8, 1'b1, s, co, lat);
        checks++;
        if ({co, s} !== 5'h12 || lat !== 1) begin
            errors++;
            $display("FAIL w4_directed got %h lat %0d want 12 lat 1", {co, s}, lat);
        end
        for (int i = 0; i < 20; i++) begin
            x    = 4'($urandom);
            y    = 4'($urandom);
            c    = 1'($urandom);
            want = {1'b0, x} + {1'b0, y} + {4'b0, c};
            run4(x, y, c, s, co, lat);
            checks++;
            if ({co, s} !== want || lat !== 1) begin
                errors++;
                $display("FAIL w4_random%0d %h+%h+%b got %h lat %0d want %h lat 1",
                         i, x, y, c, {co, s}, lat, want);
            end
        end
        checks++;
        if ({in_ready4, out_valid4} !== 2'b10) begin
            errors++;
            $display("FAIL w4_idle got rdy=%b ov=%b want 1 0", in_ready4, out_valid4);
        end
    endtask

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [15:0] va [3] = '{16'h7FFF, 16'h8000, 16'h1234};
        logic [15:0] vb [3] = '{16'h0001, 16'hFFFF, 16'h4321};
        logic [17:0] want [3] = '{{1'b1, 17'h08000}, {1'b1, 17'h17FFF}, {1'b0, 17'h05555}};
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          lat;
        bit          rb;
        for (int i = 0; i < 3; i++) begin
            run16(va[i], vb[i], 1'b0, s, co, ov, lat, rb);
            checks++;
            if ({ov, co, s} !== want[i]) begin
                errors++;
                $display("FAIL ovf%0d got ovf=%b %h want %h", i, ov, {co, s}, want[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_width4();
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
